screen_coord_gen: RTL and testbench
===================================

SCREEN_COORD_GEN -- requirements
Module: screen_coord_gen

Interface
REQ-001 Parameter SCREEN_WIDTH, default 640 (from network_params.h), active pixels per line.
REQ-002 Parameter SCREEN_HEIGHT, default 480 (from network_params.h), active lines per frame.
REQ-003 Width macros SCREEN_X_BITWIDTH, SCREEN_Y_BITWIDTH, CAMERA_PIXEL_BITWIDTH SHALL be taken from network_params.h; each port width is the macro value plus one.
REQ-004 clock  input  1  clock; all logic SHALL be rising-edge.
REQ-005 reset  input  1  reset, asynchronous, active-low.
REQ-006 frame_valid  input  1  camera frame-active level.
REQ-007 line_valid  input  1  camera line-active level.
REQ-008 pixel_valid  input  1  pixel_in carries a pixel this cycle.
REQ-009 pixel_in  input  CAMERA_PIXEL_BITWIDTH+1  camera pixel data.
REQ-010 screen_x  output  SCREEN_X_BITWIDTH+1  column of pixel_out.
REQ-011 screen_y  output  SCREEN_Y_BITWIDTH+1  row of pixel_out.
REQ-012 pixel_out  output  CAMERA_PIXEL_BITWIDTH+1  registered pixel.
REQ-013 pixel_out_valid  output  1  one-cycle strobe; pixel_out/screen_x/screen_y valid.
REQ-014 frame_start  output  1  one-cycle pulse coincident with the pixel at (0,0).
REQ-015 line_end  output  1  one-cycle pulse the cycle after line_valid falls in IN_LINE.
REQ-016 coord_err  output  1  sticky geometry error (present only under REQ-032).

Function
REQ-017 States SHALL be SYNC, WAIT_FRAME, LINE_GAP, IN_LINE.
REQ-018 SYNC -> WAIT_FRAME when frame_valid==0; the block SHALL never lock onto a frame already in progress.
REQ-019 WAIT_FRAME -> LINE_GAP when frame_valid==1; internal x=0, y=0.
REQ-020 A pixel SHALL be accepted when state is LINE_GAP or IN_LINE and frame_valid, line_valid and pixel_valid are all 1; LINE_GAP -> IN_LINE on the first accepted pixel.
REQ-021 Accepted pixel with x<SCREEN_WIDTH and y<SCREEN_HEIGHT: next cycle pixel_out_valid=1, pixel_out=pixel_in, screen_x=x, screen_y=y; x increments (latency exactly 1 cycle).
REQ-022 Accepted pixel with x>=SCREEN_WIDTH or y>=SCREEN_HEIGHT SHALL be dropped (no strobe); x saturates at SCREEN_WIDTH, y saturates at SCREEN_HEIGHT; no wrap.
REQ-023 IN_LINE with line_valid==0 -> LINE_GAP: x=0, y=y+1 (saturating), line_end pulses.
REQ-024 frame_valid==0 in LINE_GAP or IN_LINE -> WAIT_FRAME with x=0, y=0; if simultaneous with line_valid falling, line_end SHALL still pulse.
REQ-025 pixel_valid with line_valid==0, or any input in SYNC/WAIT_FRAME, SHALL be ignored.
REQ-026 screen_x, screen_y, pixel_out SHALL hold last emitted values when pixel_out_valid==0.
REQ-027 frame_start=1 exactly when the emitted pixel has screen_x==0 and screen_y==0.

Reset
REQ-028 Reset assertion SHALL force state SYNC, x=0, y=0 asynchronously.
REQ-029 All outputs SHALL reset to 0 (screen_x, screen_y, pixel_out, pixel_out_valid, frame_start, line_end, coord_err).
REQ-030 Reset mid-frame SHALL discard the frame; output resumes only after a full frame_valid low-then-high sequence.
REQ-031 No output SHALL depend on reset deassertion timing beyond the first clock edge after release.

Configuration
REQ-032 Macro SCREEN_COORD_ERR_EN: defined -> coord_err sets on a dropped pixel (REQ-022) or a line ending with x<SCREEN_WIDTH while y<SCREEN_HEIGHT, and clears only on reset; undefined -> coord_err port and its logic are absent, behaviour otherwise identical.

Verification (bench build SCREEN_WIDTH=8, SCREEN_HEIGHT=4)
REQ-033 Reset release with frame_valid=1, 8 pixels driven -> no pixel_out_valid until frame_valid toggles 0 then 1.
REQ-034 Full frame 4 lines x 8 pixels, pixel_in=16*y+x -> 32 strobes, each pixel_out matches coordinates, frame_start once at (0,0), line_end 4 times.
REQ-035 Line with 10 pixels -> strobes for x=0..7 only, screen_x holds 7; with SCREEN_COORD_ERR_EN coord_err=1.
REQ-036 pixel_valid toggling 1/0 inside a line -> 8 strobes, x contiguous 0..7, gaps produce no strobe.
REQ-037 Reset asserted at (x=3,y=1) -> all outputs 0 immediately; next frame starts at (0,0).
REQ-038 frame_valid and line_valid fall same cycle after line 2 -> line_end pulses once, next frame's first pixel at (0,0).

Source files
------------

// File: rtl/screen_coord_gen.sv
// ---------------------------------------------------------------------------
// screen_coord_gen
//
// Attaches screen coordinates to a camera pixel stream. The block waits for
// a clean frame boundary (frame_valid low, then high), counts accepted pixels
// along each line and lines within the frame, and emits each in-range pixel
// one cycle later together with its (screen_x, screen_y). Pixels outside the
// SCREEN_WIDTH x SCREEN_HEIGHT window are dropped; the counters saturate at
// the window edge instead of wrapping.
//
// Ports
//   clock            rising-edge clock
//   reset            asynchronous, active-low reset
//   frame_valid      camera frame-active level
//   line_valid       camera line-active level
//   pixel_valid      pixel_in carries a pixel this cycle
//   pixel_in         camera pixel data
//   screen_x         column of pixel_out (holds when no strobe)
//   screen_y         row of pixel_out (holds when no strobe)
//   pixel_out        registered pixel (holds when no strobe)
//   pixel_out_valid  one-cycle strobe, pixel_out/screen_x/screen_y valid
//   frame_start      one-cycle pulse with the pixel emitted at (0,0)
//   line_end         one-cycle pulse the cycle after a line closes
//   coord_err        sticky geometry error (only with SCREEN_COORD_ERR_EN)
//
// Build options
//   SCREEN_COORD_ERR_EN  when defined, adds the coord_err output, which sets
//                        on a dropped pixel or on a line that ends short of
//                        SCREEN_WIDTH inside the window, and clears on reset.
//   SCREEN_X_BITWIDTH, SCREEN_Y_BITWIDTH, CAMERA_PIXEL_BITWIDTH come from the
//   network parameter header; the defaults below are used when that header
//   has not been seen. Each port is the macro value plus one bits wide.
// ---------------------------------------------------------------------------

`ifndef SCREEN_X_BITWIDTH
`define SCREEN_X_BITWIDTH 9
`endif
`ifndef SCREEN_Y_BITWIDTH
`define SCREEN_Y_BITWIDTH 8
`endif
`ifndef CAMERA_PIXEL_BITWIDTH
`define CAMERA_PIXEL_BITWIDTH 7
`endif

// state      | meaning
// -----------+-------------------------------------------------------------
// SYNC       | after reset; waiting for frame_valid low so that a frame
//            | already in progress is never picked up half-way
// WAIT_FRAME | between frames; frame_valid high starts a new frame at (0,0)
// LINE_GAP   | inside a frame, between lines; first accepted pixel opens a line
// IN_LINE    | inside a line; line_valid low closes it and advances the row

module screen_coord_gen #(
    parameter int SCREEN_WIDTH  = 640,
    parameter int SCREEN_HEIGHT = 480
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              frame_valid,
    input  logic                              line_valid,
    input  logic                              pixel_valid,
    input  logic [`CAMERA_PIXEL_BITWIDTH:0]   pixel_in,
    output logic [`SCREEN_X_BITWIDTH:0]       screen_x,
    output logic [`SCREEN_Y_BITWIDTH:0]       screen_y,
    output logic [`CAMERA_PIXEL_BITWIDTH:0]   pixel_out,
    output logic                              pixel_out_valid,
    output logic                              frame_start,
`ifdef SCREEN_COORD_ERR_EN
    output logic                              line_end,
    output logic                              coord_err
`else
    output logic                              line_end
`endif
);

    localparam int XW = `SCREEN_X_BITWIDTH + 1;
    localparam int YW = `SCREEN_Y_BITWIDTH + 1;

    localparam logic [XW-1:0] X_LIM = XW'(SCREEN_WIDTH);
    localparam logic [YW-1:0] Y_LIM = YW'(SCREEN_HEIGHT);

    localparam logic [1:0] ST_SYNC       = 2'd0;
    localparam logic [1:0] ST_WAIT_FRAME = 2'd1;
    localparam logic [1:0] ST_LINE_GAP   = 2'd2;
    localparam logic [1:0] ST_IN_LINE    = 2'd3;

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [XW-1:0] x_cnt;
    logic [XW-1:0] x_nxt;
    logic [YW-1:0] y_cnt;
    logic [YW-1:0] y_nxt;

    logic x_in_win;
    logic y_in_win;
    logic emit;
    logic drop;
    logic line_close;

    assign x_in_win = (x_cnt < X_LIM);
    assign y_in_win = (y_cnt < Y_LIM);

    always_comb begin
        state_nxt  = state;
        x_nxt      = x_cnt;
        y_nxt      = y_cnt;
        emit       = 1'b0;
        drop       = 1'b0;
        line_close = 1'b0;

        case (state)
            ST_SYNC: begin
                if (!frame_valid) begin
                    state_nxt = ST_WAIT_FRAME;
                end
            end

            ST_WAIT_FRAME: begin
                if (frame_valid) begin
                    state_nxt = ST_LINE_GAP;
                    x_nxt     = '0;
                    y_nxt     = '0;
                end
            end

            ST_LINE_GAP, ST_IN_LINE: begin
                // A line that closes in the same cycle as the frame still
                // reports line_end, so line_close is decoded independently
                // of frame_valid.
                line_close = (state == ST_IN_LINE) && !line_valid;

                if (!frame_valid) begin
                    state_nxt = ST_WAIT_FRAME;
                    x_nxt     = '0;
                    y_nxt     = '0;
                end else if (line_close) begin
                    state_nxt = ST_LINE_GAP;
                    x_nxt     = '0;
                    if (y_in_win) begin
                        y_nxt = y_cnt + YW'(1);
                    end
                end else if (line_valid && pixel_valid) begin
                    state_nxt = ST_IN_LINE;
                    if (x_in_win && y_in_win) begin
                        emit  = 1'b1;
                        // x < X_LIM here, so the increment stops at X_LIM.
                        x_nxt = x_cnt + XW'(1);
                    end else begin
                        drop  = 1'b1;
                    end
                end
            end

            default: begin
                state_nxt = ST_SYNC;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ST_SYNC;
            x_cnt <= '0;
            y_cnt <= '0;
        end else begin
            state <= state_nxt;
            x_cnt <= x_nxt;
            y_cnt <= y_nxt;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            screen_x        <= '0;
            screen_y        <= '0;
            pixel_out       <= '0;
            pixel_out_valid <= 1'b0;
            frame_start     <= 1'b0;
            line_end        <= 1'b0;
        end else begin
            pixel_out_valid <= emit;
            frame_start     <= emit && (x_cnt == '0) && (y_cnt == '0);
            line_end        <= line_close;
            if (emit) begin
                screen_x  <= x_cnt;
                screen_y  <= y_cnt;
                pixel_out <= pixel_in;
            end
        end
    end

`ifdef SCREEN_COORD_ERR_EN
    logic short_line;

    // A line closing inside the window before reaching the right edge.
    assign short_line = line_close && x_in_win && y_in_win;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            coord_err <= 1'b0;
        end else if (drop || short_line) begin
            coord_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_screen_coord_gen.sv
`ifndef SCREEN_X_BITWIDTH
`define SCREEN_X_BITWIDTH 9
`endif
`ifndef SCREEN_Y_BITWIDTH
`define SCREEN_Y_BITWIDTH 8
`endif
`ifndef CAMERA_PIXEL_BITWIDTH
`define CAMERA_PIXEL_BITWIDTH 7
`endif

module tb_screen_coord_gen;

    localparam int W  = 8;
    localparam int H  = 4;
    localparam int PW = `CAMERA_PIXEL_BITWIDTH + 1;

    logic                            clock = 1'b0;
    logic                            reset = 1'b0;
    logic                            frame_valid = 1'b0;
    logic                            line_valid = 1'b0;
    logic                            pixel_valid = 1'b0;
    logic [`CAMERA_PIXEL_BITWIDTH:0] pixel_in = '0;
    logic [`SCREEN_X_BITWIDTH:0]     screen_x;
    logic [`SCREEN_Y_BITWIDTH:0]     screen_y;
    logic [`CAMERA_PIXEL_BITWIDTH:0] pixel_out;
    logic                            pixel_out_valid;
    logic                            frame_start;
    logic                            line_end;
`ifdef SCREEN_COORD_ERR_EN
    logic                            coord_err;
`endif

    screen_coord_gen #(.SCREEN_WIDTH(W), .SCREEN_HEIGHT(H)) dut (
        .clock           (clock),
        .reset           (reset),
        .frame_valid     (frame_valid),
        .line_valid      (line_valid),
        .pixel_valid     (pixel_valid),
        .pixel_in        (pixel_in),
        .screen_x        (screen_x),
        .screen_y        (screen_y),
        .pixel_out       (pixel_out),
        .pixel_out_valid (pixel_out_valid),
        .frame_start     (frame_start),
`ifdef SCREEN_COORD_ERR_EN
        .line_end        (line_end),
        .coord_err       (coord_err)
`else
        .line_end        (line_end)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        int x;
        int y;
        int pix;
    } pix_t;

    // reference: strobes the frame geometry rules predict
    pix_t exp_q[$];
    int   exp_le  = 0;
    int   exp_fs  = 0;
    bit   exp_err = 1'b0;

    // observations
    pix_t obs_q[$];
    pix_t mon_e;
    int   le_cnt = 0;
    int   fs_cnt = 0;
    int   fs_bad = 0;

    int tests = 0;
    int fails = 0;

    always @(negedge clock) begin
        if (reset) begin
            if (pixel_out_valid) begin
                mon_e.x   = int'(screen_x);
                mon_e.y   = int'(screen_y);
                mon_e.pix = int'(pixel_out);
                obs_q.push_back(mon_e);
            end
            if (line_end) le_cnt++;
            if (frame_start) fs_cnt++;
            if (frame_start !== (pixel_out_valid && screen_x == 0 && screen_y == 0)) fs_bad++;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", tests, fails);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int observed, input int expected);
        tests++;
        assert (observed === expected) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic step(input logic fv, input logic lv, input logic pv, input int pix);
        frame_valid = fv;
        line_valid  = lv;
        pixel_valid = pv;
        pixel_in    = PW'(pix);
        @(posedge clock);
        #1;
    endtask

    // frame active, no line; stray pixel_valid must be ignored
    task automatic gap(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'($urandom % 2), int'($urandom));
    endtask

    task automatic start_frame();
        step(1'b0, 1'b0, 1'b0, 0);
        step(1'b0, 1'b0, 1'b0, 0);
        step(1'b1, 1'b0, 1'b0, 0);
        gap(1);
    endtask

    task automatic add_exp(input int x, input int y, input int pix);
        pix_t e;
        if (x < W && y < H) begin
            e.x = x; e.y = y; e.pix = pix;
            exp_q.push_back(e);
            if (x == 0 && y == 0) exp_fs++;
        end
    endtask

    // n >= 1 pixels on row ly; the line ends either normally or together
    // with frame_valid
    task automatic send_line(input int ly, input int n, input bit gaps, input bit rnd, input bit with_frame);
        int pix;
        for (int k = 0; k < n; k++) begin
            if (gaps && ($urandom % 2 == 1)) step(1'b1, 1'b1, 1'b0, int'($urandom));
            pix = rnd ? int'($urandom % (1 << PW)) : 16 * ly + k;
            step(1'b1, 1'b1, 1'b1, pix);
            add_exp(k, ly, pix);
        end
        exp_le++;
        if (n != W || ly >= H) exp_err = 1'b1;
        if (with_frame) step(1'b0, 1'b0, 1'b0, 0);
        else gap(1 + int'($urandom % 3));
    endtask

    task automatic run_frame(input int nlines, input bit gaps, input bit rnd, input bit full, input bit end_with_line);
        start_frame();
        for (int ly = 0; ly < nlines; ly++)
            send_line(ly, full ? W : int'($urandom_range(10, 1)), gaps, rnd, end_with_line && (ly == nlines - 1));
        step(1'b0, 1'b0, 1'b0, 0);
    endtask

    task automatic check_frame(input string tag);
        int n;
        step(1'b0, 1'b0, 1'b0, 0);
        step(1'b0, 1'b0, 1'b0, 0);
        chk({tag, " strobe_count"}, obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s x[%0d]", tag, i), obs_q[i].x, exp_q[i].x);
            chk($sformatf("%s y[%0d]", tag, i), obs_q[i].y, exp_q[i].y);
            chk($sformatf("%s pix[%0d]", tag, i), obs_q[i].pix, exp_q[i].pix);
        end
        chk({tag, " line_end_count"}, le_cnt, exp_le);
        chk({tag, " frame_start_count"}, fs_cnt, exp_fs);
        chk({tag, " frame_start_placement"}, fs_bad, 0);
`ifdef SCREEN_COORD_ERR_EN
        chk({tag, " coord_err"}, int'(coord_err), int'(exp_err));
`endif
        obs_q.delete();
        exp_q.delete();
        le_cnt = 0; fs_cnt = 0; fs_bad = 0;
        exp_le = 0; exp_fs = 0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, " pixel_out_valid"}, int'(pixel_out_valid), 0);
        chk({tag, " screen_x"}, int'(screen_x), 0);
        chk({tag, " screen_y"}, int'(screen_y), 0);
        chk({tag, " pixel_out"}, int'(pixel_out), 0);
        chk({tag, " frame_start"}, int'(frame_start), 0);
        chk({tag, " line_end"}, int'(line_end), 0);
`ifdef SCREEN_COORD_ERR_EN
        chk({tag, " coord_err"}, int'(coord_err), 0);
`endif
    endtask

    initial begin
        // reset state, released in the middle of a frame
        frame_valid = 1'b1;
        #3;
        check_zero("reset");
        @(posedge clock);
        #3;
        reset = 1'b1;
        @(posedge clock);
        #1;
        for (int k = 0; k < 8; k++) step(1'b1, 1'b1, 1'b1, k);
        step(1'b1, 1'b0, 1'b0, 0);
        check_frame("locked_mid_frame");

        // full frame, pixel = 16*y + x
        run_frame(4, 1'b0, 1'b0, 1'b1, 1'b0);
        check_frame("full_frame");

        // pixel_valid gaps inside a line
        run_frame(1, 1'b1, 1'b1, 1'b1, 1'b0);
        check_frame("gapped_line");

        // line 2 ends together with the frame, then a fresh frame
        start_frame();
        send_line(0, W, 1'b0, 1'b1, 1'b0);
        send_line(1, W, 1'b0, 1'b1, 1'b0);
        send_line(2, W, 1'b0, 1'b1, 1'b1);
        run_frame(1, 1'b0, 1'b1, 1'b1, 1'b0);
        check_frame("joint_fall");

        // overlong line: only x = 0..7 emitted, screen_x holds last column
        run_frame(1, 1'b0, 1'b0, 1'b0, 1'b0);
        start_frame();
        send_line(0, 10, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 0);
        check_frame("long_line");
        chk("long_line screen_x_hold", int'(screen_x), W - 1);

        // randomized geometry, including too many lines
        for (int f = 0; f < 6; f++) begin
            run_frame(int'($urandom_range(6, 1)), 1'b1, 1'b1, 1'b0, 1'($urandom % 4 == 0));
            check_frame($sformatf("random_frame%0d", f));
        end

        // reset at (x=3, y=1)
        start_frame();
        send_line(0, W, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b1, 1'b1, 16 + k);
            add_exp(k, 1, 16 + k);
        end
        step(1'b1, 1'b1, 1'b0, 0);
        chk("pre_reset screen_x", int'(screen_x), 2);
        #2;
        reset = 1'b0;
        #1;
        check_zero("mid_frame_reset");
        chk("mid_frame_reset strobe_count", obs_q.size(), exp_q.size());
        chk("mid_frame_reset line_end_count", le_cnt, exp_le);
        obs_q.delete();
        exp_q.delete();
        le_cnt = 0; fs_cnt = 0; fs_bad = 0;
        exp_le = 0; exp_fs = 0; exp_err = 1'b0;
        #3;
        reset = 1'b1;
        @(posedge clock);
        #1;
        for (int k = 3; k < 8; k++) step(1'b1, 1'b1, 1'b1, k);
        step(1'b1, 1'b0, 1'b0, 0);
        for (int k = 0; k < 8; k++) step(1'b1, 1'b1, 1'b1, k);
        step(1'b1, 1'b0, 1'b0, 0);
        run_frame(4, 1'b0, 1'b0, 1'b1, 1'b0);
        check_frame("after_reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
